// File: rtl/eth_udp_pkg.sv
// Shared constants and state encoding for the eth_udp_test transmit path.
package eth_udp_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  localparam int UDP_MAX_PAYLOAD = 1472;
  localparam int LEN_W_DEF       = 16;
  localparam int IFG_CYCLES      = 12;
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: first set request strictly after ptr, wrapping around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          vld
);
  logic [IW-1:0] cand;

  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end
endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin scheduler sharing one UDP transmit engine between NUM_REQ packet sources.
// Grants one source per frame, forwards engine byte pulls, enforces IFG and a completion timeout.
module udp_tx_arbiter
  import eth_udp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int MAX_LEN = UDP_MAX_PAYLOAD,
  parameter int MIN_GAP = IFG_CYCLES,
  parameter int TIMEOUT = 65535
) (
  input  logic                     rgmii_clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]     req_data,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic [NUM_REQ-1:0]       req_rd,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [NUM_REQ-1:0]       req_err,
  input  logic                     eng_ready,
  output logic                     eng_start,
  output logic [LEN_W-1:0]         eng_len,
  input  logic                     eng_data_req,
  output logic [7:0]               eng_data,
  input  logic                     eng_done,
  output logic                     busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
  // Counter starts the cycle after eng_start, so matching TIMEOUT-2 aborts exactly TIMEOUT cycles after it
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  logic [NUM_REQ-1:0][LEN_W-1:0] len_a;
  logic [NUM_REQ-1:0][7:0]       dat_a;
  assign len_a = req_len;
  assign dat_a = req_data;

  tx_state_e        state;
  logic [IW-1:0]    rr_ptr, gidx, win_idx;
  logic             win_vld, len_bad;
  logic [LEN_W-1:0] win_len, byte_cnt;
  logic [TW-1:0]    tmo;
  logic [GW-1:0]    gap_cnt;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (win_idx),
    .vld (win_vld)
  );

  assign win_len = len_a[win_idx];
  assign len_bad = (win_len == '0) || (int'(win_len) > MAX_LEN);

  assign req_rd = req_grant & {NUM_REQ{eng_data_req}};

  // Past eng_len the engine is padding; feed zeros rather than whatever the source holds
  always_comb begin
    eng_data = 8'h00;
    if (|req_grant && (byte_cnt < eng_len)) eng_data = dat_a[gidx];
  end

  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= IW'(NUM_REQ - 1);
      gidx      <= '0;
      req_grant <= '0;
      req_done  <= '0;
      req_err   <= '0;
      eng_start <= 1'b0;
      eng_len   <= '0;
      byte_cnt  <= '0;
      tmo       <= '0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      req_done  <= '0;
      req_err   <= '0;
      eng_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (eng_ready && win_vld) begin
            rr_ptr <= win_idx;
            if (len_bad) begin
              req_err[win_idx] <= 1'b1;
            end else begin
              req_grant[win_idx] <= 1'b1;
              gidx      <= win_idx;
              eng_len   <= win_len;
              eng_start <= 1'b1;
              byte_cnt  <= '0;
              busy      <= 1'b1;
              state     <= ST_START;
            end
          end
        end
        ST_START: begin
          byte_cnt <= '0;
          tmo      <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          tmo <= tmo + TW'(1);
          if (eng_data_req && (byte_cnt != eng_len)) byte_cnt <= byte_cnt + LEN_W'(1);
          if (eng_done || (tmo == TMO_LAST)) begin
            if (eng_done) req_done[gidx] <= 1'b1;
            else          req_err[gidx]  <= 1'b1;
            req_grant <= '0;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (int'(gap_cnt) + 1 >= MIN_GAP) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed + randomized bench for udp_tx_arbiter against a round-robin reference model.
module tb_udp_tx_arbiter;
  localparam int NR  = 4;
  localparam int IW  = 2;
  localparam int TMO = 100;
  localparam int GAP = 12;

  logic               rgmii_clk, rst;
  logic [NR-1:0]      req_valid, req_grant, req_rd, req_done, req_err;
  logic [NR-1:0][15:0] len_v;
  logic [NR-1:0][7:0]  dat_v;
  logic               eng_ready, eng_start, eng_data_req, eng_done, busy;
  logic [15:0]        eng_len;
  logic [7:0]         eng_data;

  udp_tx_arbiter #(.NUM_REQ(NR), .LEN_W(16), .MAX_LEN(1472), .MIN_GAP(GAP), .TIMEOUT(TMO)) dut (
    .rgmii_clk(rgmii_clk), .rst(rst), .req_valid(req_valid), .req_len(len_v), .req_data(dat_v),
    .req_grant(req_grant), .req_rd(req_rd), .req_done(req_done), .req_err(req_err),
    .eng_ready(eng_ready), .eng_start(eng_start), .eng_len(eng_len), .eng_data_req(eng_data_req),
    .eng_data(eng_data), .eng_done(eng_done), .busy(busy)
  );

  initial rgmii_clk = 1'b0;
  always #4 rgmii_clk = ~rgmii_clk;

  int            n_vec, n_mis, last, g;
  logic [NR-1:0] pend, nw, rd_s;
  int            rptr [NR];
  int            lens [NR];
  logic [7:0]    src  [NR][256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    return NR'(1) << i;
  endfunction

  // Reference arbitration: first pending index after the last winner, wrapping
  function automatic int pick(input logic [NR-1:0] p, input int lw);
    for (int d = 1; d <= NR; d++)
      if (p[IW'((lw + d) % NR)]) return (lw + d) % NR;
    return -1;
  endfunction

  task automatic set_len(input int i, input int v);
    len_v[IW'(i)] = 16'(v);
    lens[IW'(i)]  = v;
  endtask

  task automatic drive_src();
    for (int i = 0; i < NR; i++) dat_v[IW'(i)] = src[IW'(i)][8'(rptr[IW'(i)])];
  endtask

  // One clock: sources advance on the bytes pulled this cycle; returns at the next negedge
  task automatic clk1();
    #1;
    rd_s = req_rd;
    @(posedge rgmii_clk);
    #1;
    for (int i = 0; i < NR; i++) if (rd_s[IW'(i)]) rptr[IW'(i)] = rptr[IW'(i)] + 1;
    drive_src();
    @(negedge rgmii_clk);
  endtask

  task automatic gap_check();
    for (int m = 1; m <= GAP; m++) begin
      clk1();
      chk("gap_nogrant", 32'(req_grant), 0);
      if (m < GAP) chk("gap_busy", 32'(busy), 1);
    end
    chk("gap_idle", 32'(busy), 0);
  endtask

  // Called in IDLE with the request presented; arbitration happens on the next edge
  task automatic frame(input int gw, input int len, input int npull, input int done_at,
                       input bit keep, input bit exp_to);
    int j, base;
    logic [7:0] eb;
    clk1();
    chk("grant", 32'(req_grant), 1 << gw);
    chk("eng_start", 32'(eng_start), 1);
    chk("eng_len", 32'(eng_len), 32'(len));
    chk("busy", 32'(busy), 1);
    if (!keep) req_valid = req_valid & ~oh(gw);
    base = rptr[IW'(gw)];
    clk1();
    j = 1;
    chk("start_one_cycle", 32'(eng_start), 0);
    while (j <= 400 && req_done == '0 && req_err == '0) begin
      if (j <= npull) begin
        eng_data_req = 1'b1;
        #1;
        eb = (j - 1 < len) ? src[IW'(gw)][8'(base + j - 1)] : 8'h00;
        chk("req_rd", 32'(req_rd), 1 << gw);
        chk("eng_data", 32'(eng_data), 32'(eb));
        chk("eng_len_hold", 32'(eng_len), 32'(len));
      end
      if (j == done_at) eng_done = 1'b1;
      clk1();
      eng_data_req = 1'b0;
      eng_done     = 1'b0;
      j++;
    end
    if (exp_to) begin
      chk("timeout_cycle", 32'(j), TMO);
      chk("timeout_err", 32'(req_err), 1 << gw);
      chk("timeout_nodone", 32'(req_done), 0);
    end else begin
      chk("done_cycle", 32'(j), 32'(done_at + 1));
      chk("done", 32'(req_done), 1 << gw);
      chk("done_noerr", 32'(req_err), 0);
    end
    chk("grant_clear", 32'(req_grant), 0);
    chk("busy_gap", 32'(busy), 1);
    gap_check();
  endtask

  initial begin
    int ln, np;
    rst = 1'b1; req_valid = '0; len_v = '0; dat_v = '0;
    eng_ready = 1'b1; eng_data_req = 1'b0; eng_done = 1'b0;
    n_vec = 0; n_mis = 0; last = NR - 1; pend = '0;
    for (int i = 0; i < NR; i++) begin
      rptr[IW'(i)] = 0;
      lens[IW'(i)] = 0;
      for (int k = 0; k < 256; k++) src[IW'(i)][8'(k)] = 8'($urandom);
    end
    drive_src();
    @(negedge rgmii_clk);
    clk1(); clk1();
    chk("rst_grant", 32'(req_grant), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_err", 32'(req_err), 0);
    chk("rst_start", 32'(eng_start), 0);
    chk("rst_len", 32'(eng_len), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    // Fairness with all four held
    for (int i = 0; i < NR; i++) set_len(i, 4);
    req_valid = '1; pend = '1;
    for (int f = 0; f < 6; f++) begin
      g = pick(pend, last); last = g;
      frame(g, 4, 4, 5, 1'b1, 1'b0);
    end
    req_valid = '0; pend = '0;

    // Single request, first held off by eng_ready
    eng_ready = 1'b0; set_len(0, 8); req_valid = 4'b0001;
    clk1(); clk1();
    chk("not_ready_grant", 32'(req_grant), 0);
    chk("not_ready_busy", 32'(busy), 0);
    eng_ready = 1'b1;
    g = pick(4'b0001, last); last = g;
    frame(g, 8, 8, 9, 1'b0, 1'b0);

    // Timeout with a silent engine
    set_len(2, 8); req_valid = 4'b0100;
    g = pick(4'b0100, last); last = g;
    frame(g, 8, 3, 0, 1'b0, 1'b1);

    // Illegal lengths are rejected without starting the engine
    set_len(0, 0); set_len(1, 1500); req_valid = 4'b0011; pend = 4'b0011;
    for (int e = 0; e < 2; e++) begin
      g = pick(pend, last); last = g;
      clk1();
      chk("badlen_err", 32'(req_err), 1 << g);
      chk("badlen_start", 32'(eng_start), 0);
      chk("badlen_busy", 32'(busy), 0);
      req_valid = req_valid & ~oh(g);
      pend = pend & ~oh(g);
    end
    clk1();
    chk("badlen_quiet_err", 32'(req_err), 0);
    chk("badlen_quiet_start", 32'(eng_start), 0);

    // Overrun pulls plus eng_done on the timeout cycle
    set_len(3, 4); req_valid = 4'b1000;
    g = pick(4'b1000, last); last = g;
    frame(g, 4, 6, TMO - 1, 1'b0, 1'b0);

    // Randomized traffic
    for (int r = 0; r < 8; r++) begin
      nw = NR'($urandom_range(1, 15)) & ~pend;
      for (int i = 0; i < NR; i++) if (nw[IW'(i)]) set_len(i, $urandom_range(1, 24));
      pend = pend | nw;
      req_valid = pend;
      g = pick(pend, last); last = g;
      ln = lens[IW'(g)];
      np = ln + $urandom_range(0, 2);
      frame(g, ln, np, np + $urandom_range(1, 4), 1'b0, 1'b0);
      pend = pend & ~oh(g);
    end
    req_valid = '0; pend = '0;
    clk1();

    // Reset in the middle of a frame
    set_len(2, 10); req_valid = 4'b0100;
    g = pick(4'b0100, last);
    clk1();
    chk("mid_grant", 32'(req_grant), 1 << g);
    clk1();
    eng_data_req = 1'b1;
    clk1(); clk1();
    rst = 1'b1;
    clk1();
    chk("mid_rst_grant", 32'(req_grant), 0);
    chk("mid_rst_rd", 32'(req_rd), 0);
    chk("mid_rst_done", 32'(req_done), 0);
    chk("mid_rst_err", 32'(req_err), 0);
    chk("mid_rst_start", 32'(eng_start), 0);
    chk("mid_rst_len", 32'(eng_len), 0);
    chk("mid_rst_data", 32'(eng_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0; eng_data_req = 1'b0; last = NR - 1;
    for (int i = 0; i < NR; i++) set_len(i, 5);
    req_valid = '1;
    g = pick('1, last); last = g;
    frame(g, 5, 5, 6, 1'b0, 1'b0);
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
